// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared FSM encoding and sizing helper for serial_adder.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Beat counter width: clog2(WIDTH/SLICE), never narrower than one bit.
  function automatic int cnt_width(input int width, input int slice);
    int beats;
    if (slice < 1) return 1;
    beats = width / slice;
    if (beats <= 1) return 1;
    return $clog2(beats);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fa_bit.sv
`default_nettype none
// ============================================================================
//  Module   : fa_bit
//  Purpose  : One-bit combinational full adder made of two half-adder stages.
//  Revision : 1.0 - initial release
// ============================================================================
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  // First half adder combines the operands, second folds in the carry.
  assign w_s1 = a ^ b;
  assign w_c1 = a & b;
  assign s    = w_s1 ^ cin;
  assign w_c2 = w_s1 & cin;
  assign co   = w_c1 | w_c2;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Multi-cycle WIDTH-bit adder, SLICE bits per clock through a
//             chain of fa_bit cells with a registered carry between beats.
//             Valid/ready handshake on input and output.
//  Options  : SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            N    = WIDTH / SLICE;
  localparam int            CW   = cnt_width(WIDTH, SLICE);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Refuse to build a configuration that cannot be sliced evenly.
  if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $fatal(1, "serial_adder: SLICE must divide WIDTH and both must be >= 1");
  end

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic [CW-1:0]        cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic                 ovf_q, ovf_d;
`endif

  logic [SLICE-1:0]     w_s;
  logic [SLICE:0]       w_c;

  // Carry ripples from the carry register through SLICE chained cells.
  assign w_c[0] = carry_q;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    fa_bit u_fa (
      .a   (a_q[i]),
      .b   (b_q[i]),
      .cin (w_c[i]),
      .s   (w_s[i]),
      .co  (w_c[i+1])
    );
  end

  // Next-state, operand shifting and result accumulation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Result bits enter at the MSB end so after N beats bit 0 is at the bottom.
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        sum_d   = (sum_q >> SLICE) | (WIDTH'(w_s) << (WIDTH - SLICE));
        carry_d = w_c[SLICE];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // On the last beat the top cell is bit WIDTH-1.
          ovf_d   = w_c[SLICE-1] ^ w_c[SLICE];
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Directed self-checking bench for serial_adder (8/1, 8/4, 16/16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, ci8, co8;
  logic [7:0] a8, b8, s8;
  logic       iv4, ir4, ov4, or4, ci4, co4;
  logic [7:0] a4, b4, s4;
  logic        iv16, ir16, ov16, or16, ci16, co16;
  logic [15:0] a16, b16, s16;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf4, ovf16;
`endif

  int n_pass  = 0;
  int n_total = 0;

  serial_adder #(.WIDTH(8), .SLICE(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(8), .SLICE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_adder #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  function automatic logic get_ov(input int sel);
    case (sel)
      0:       return ov8;
      1:       return ov4;
      default: return ov16;
    endcase
  endfunction

  // Present operands, wait for the accept edge, then count edges to out_valid.
  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input bit toggle, output int lat);
    case (sel)
      0:       begin a8  = av[7:0]; b8  = bv[7:0]; ci8  = c; iv8  = 1'b1; end
      1:       begin a4  = av[7:0]; b4  = bv[7:0]; ci4  = c; iv4  = 1'b1; end
      default: begin a16 = av;      b16 = bv;      ci16 = c; iv16 = 1'b1; end
    endcase
    @(posedge clk); #1;
    iv8 = 1'b0; iv4 = 1'b0; iv16 = 1'b0;
    lat = 0;
    while (!get_ov(sel) && lat < 100) begin
      if (toggle) begin
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) lat = -1;
  endtask

  task automatic release_result(input int sel);
    case (sel)
      0:       or8  = 1'b1;
      1:       or4  = 1'b1;
      default: or16 = 1'b1;
    endcase
    @(posedge clk); #1;
    or8 = 1'b0; or4 = 1'b0; or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++; if (ir8 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir8); else n_pass++;
    n_total++; if (ov8 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ov8); else n_pass++;
    n_total++; if (s8 !== 8'h00) $display("FAIL reset_sum got %h want 00", s8); else n_pass++;
    n_total++; if (co8 !== 1'b0) $display("FAIL reset_cout got %b want 0", co8); else n_pass++;
    n_total++; if (ir4 !== 1'b1 || ir16 !== 1'b1) $display("FAIL reset_in_ready_others got %b%b want 11", ir4, ir16); else n_pass++;
    n_total++; if (s16 !== 16'h0000) $display("FAIL reset_sum16 got %h want 0000", s16); else n_pass++;
`ifdef SERIAL_ADDER_OVF_EN
    n_total++; if (ovf8 !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf8); else n_pass++;
`endif
  endtask

  task automatic test_basic();
    int lat;
    run_op(0, 16'h0F, 16'h01, 1'b0, 1'b0, lat);
    n_total++; if (lat !== 8) $display("FAIL basic_latency got %0d want 8", lat); else n_pass++;
    n_total++; if (s8 !== 8'h10) $display("FAIL basic_sum_0f01 got %h want 10", s8); else n_pass++;
    n_total++; if (co8 !== 1'b0) $display("FAIL basic_cout_0f01 got %b want 0", co8); else n_pass++;
    release_result(0);
    n_total++; if (ov8 !== 1'b0) $display("FAIL release_out_valid got %b want 0", ov8); else n_pass++;
    n_total++; if (ir8 !== 1'b1) $display("FAIL release_in_ready got %b want 1", ir8); else n_pass++;
    n_total++; if (s8 !== 8'h10) $display("FAIL idle_hold_sum got %h want 10", s8); else n_pass++;

    run_op(0, 16'hFF, 16'h01, 1'b0, 1'b0, lat);
    n_total++; if (s8 !== 8'h00) $display("FAIL carry_sum_ff01 got %h want 00", s8); else n_pass++;
    n_total++; if (co8 !== 1'b1) $display("FAIL carry_cout_ff01 got %b want 1", co8); else n_pass++;
    release_result(0);

    run_op(0, 16'hFF, 16'hFF, 1'b1, 1'b0, lat);
    n_total++; if (s8 !== 8'hFF) $display("FAIL max_sum_ffff1 got %h want ff", s8); else n_pass++;
    n_total++; if (co8 !== 1'b1) $display("FAIL max_cout_ffff1 got %b want 1", co8); else n_pass++;
    release_result(0);
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(0, 16'h3C, 16'h5A, 1'b0, 1'b1, lat);
    n_total++; if (s8 !== 8'h96) $display("FAIL toggle_sum got %h want 96", s8); else n_pass++;
    n_total++; if (co8 !== 1'b0) $display("FAIL toggle_cout got %b want 0", co8); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_total++; if (s8 !== 8'h96 || co8 !== 1'b0) $display("FAIL hold_result cyc %0d got %h/%b want 96/0", k, s8, co8); else n_pass++;
      n_total++; if (ir8 !== 1'b0 || ov8 !== 1'b1) $display("FAIL hold_handshake cyc %0d got ir=%b ov=%b want ir=0 ov=1", k, ir8, ov8); else n_pass++;
    end
    release_result(0);
  endtask

  task automatic test_mid_reset();
    int lat;
    a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (ov8 !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", ov8); else n_pass++;
    n_total++; if (ir8 !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", ir8); else n_pass++;
    n_total++; if (s8 !== 8'h00) $display("FAIL midrst_sum got %h want 00", s8); else n_pass++;
    run_op(0, 16'h01, 16'h01, 1'b0, 1'b0, lat);
    n_total++; if (s8 !== 8'h02 || co8 !== 1'b0) $display("FAIL after_rst_sum got %h/%b want 02/0", s8, co8); else n_pass++;
    n_total++; if (lat !== 8) $display("FAIL after_rst_latency got %0d want 8", lat); else n_pass++;
    release_result(0);
  endtask

  task automatic test_slices();
    int lat;
    run_op(1, 16'h9C, 16'h75, 1'b1, 1'b0, lat);
    n_total++; if (lat !== 2) $display("FAIL slice4_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (s4 !== 8'h12 || co4 !== 1'b1) $display("FAIL slice4_result got %h/%b want 12/1", s4, co4); else n_pass++;
    release_result(1);

    run_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    n_total++; if (lat !== 1) $display("FAIL w16_latency got %0d want 1", lat); else n_pass++;
    n_total++; if (s16 !== 16'h0000 || co16 !== 1'b1) $display("FAIL w16_wrap got %h/%b want 0000/1", s16, co16); else n_pass++;
    release_result(2);

    run_op(2, 16'h1234, 16'h4321, 1'b1, 1'b0, lat);
    n_total++; if (s16 !== 16'h5556 || co16 !== 1'b0) $display("FAIL w16_sum got %h/%b want 5556/0", s16, co16); else n_pass++;
    release_result(2);
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int lat;
    run_op(0, 16'h7F, 16'h01, 1'b0, 1'b0, lat);
    n_total++; if (ovf8 !== 1'b1 || s8 !== 8'h80) $display("FAIL ovf_7f01 got %b/%h want 1/80", ovf8, s8); else n_pass++;
    release_result(0);
    run_op(0, 16'h80, 16'h80, 1'b0, 1'b0, lat);
    n_total++; if (ovf8 !== 1'b1 || co8 !== 1'b1 || s8 !== 8'h00) $display("FAIL ovf_8080 got %b/%b/%h want 1/1/00", ovf8, co8, s8); else n_pass++;
    release_result(0);
    run_op(0, 16'h01, 16'h01, 1'b0, 1'b0, lat);
    n_total++; if (ovf8 !== 1'b0) $display("FAIL ovf_0101 got %b want 0", ovf8); else n_pass++;
    release_result(0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_mid_reset();
    test_slices();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
